// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master with chip select.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    XFER,
    WAIT_NEXT,
    CS_HOLD,
    CS_GAP
  } spi_state_t;

  localparam int EDGES_PER_BYTE = 16;

  // Clock polarity: idle level of SPI_Clk.
  function automatic logic spi_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Clock phase: 0 = sample on leading edge, 1 = shift on leading edge.
  function automatic logic spi_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-bit divider plus edge counter for one byte.
// Pulses are registered, so they are high in the cycle after the SPI_Clk edge.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter logic CPOL              = 1'b0,
  parameter int   CLKS_PER_HALF_BIT = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_En,
  output logic o_SPI_Clk,
  output logic o_Lead,
  output logic o_Trail,
  output logic o_Done
);

  localparam int HW = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);

  logic [HW-1:0] half_q;
  logic [4:0]    edge_q;
  logic          clk_q, lead_q, trail_q, done_q;
  logic          edge_now;

  assign edge_now  = i_En && (edge_q < 5'(EDGES_PER_BYTE)) && (half_q == HALF_LAST);
  assign o_SPI_Clk = clk_q;
  assign o_Lead    = lead_q;
  assign o_Trail   = trail_q;
  assign o_Done    = done_q;

  // Divide i_Clk down to SPI edges; odd edges are leading, even are trailing.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      half_q  <= '0;
      edge_q  <= '0;
      clk_q   <= CPOL;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lead_q  <= edge_now && !edge_q[0];
      trail_q <= edge_now && edge_q[0];
      done_q  <= edge_now && (edge_q == 5'(EDGES_PER_BYTE - 1));
      if (!i_En) begin
        half_q <= '0;
        edge_q <= '0;
        clk_q  <= CPOL;
      end else if (edge_now) begin
        half_q <= '0;
        edge_q <= edge_q + 5'd1;
        clk_q  <= ~clk_q;
      end else if (edge_q < 5'(EDGES_PER_BYTE)) begin
        half_q <= half_q + HW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master_cs.sv
// SPI master with chip select: byte-stream handshake in, MSB-first serial out,
// received bytes returned with a 1-based index inside the CS-low frame.
module spi_master_cs
  import spi_pkg::*;
#(
  parameter  int SPI_MODE          = 0,
  parameter  int CLKS_PER_HALF_BIT = 2,
  parameter  int MAX_BYTES_PER_CS  = 2,
  parameter  int CS_INACTIVE_CLKS  = 1,
  localparam int CW                = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic [CW-1:0] o_RX_Count,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic          o_SPI_Clk,
  input  logic          i_SPI_MISO,
  output logic          o_SPI_MOSI,
  output logic          o_SPI_CS_n
);

  localparam logic CPOL = spi_cpol(2'(SPI_MODE));
  localparam logic CPHA = spi_cpha(2'(SPI_MODE));
  localparam int   TMAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ? CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
  localparam int   TW   = $clog2(TMAX + 1);

  spi_state_t    state_q, state_d;
  logic          clk_en, ready_d, cs_n_d;
  logic          lead, trail, done;
  logic          accept, more, shift_en, sample_en;
  logic [TW-1:0] tmr_q;
  logic [CW-1:0] total_q, rx_cnt_q;
  logic [7:0]    tx_shift_q, rx_shift_q, rx_byte_q;
  logic          mosi_q, cs_n_q, ready_q, rx_dv_q, byte_done_q;

  // Zero means one byte; anything above the frame limit is clipped to it.
  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
    if (c == '0) return CW'(1);
    if (c > CW'(MAX_BYTES_PER_CS)) return CW'(MAX_BYTES_PER_CS);
    return c;
  endfunction

  assign accept    = i_TX_DV && ready_q;
  assign more      = (rx_cnt_q + CW'(1)) < total_q;
  assign shift_en  = CPHA ? lead : (trail && !done);
  assign sample_en = CPHA ? trail : lead;

  assign o_TX_Ready = ready_q;
  assign o_RX_Count = rx_cnt_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Byte  = rx_byte_q;
  assign o_SPI_MOSI = mosi_q;
  assign o_SPI_CS_n = cs_n_q;

  spi_clk_gen #(
    .CPOL              (CPOL),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
  ) u_clk_gen (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_En      (clk_en),
    .o_SPI_Clk (o_SPI_Clk),
    .o_Lead    (lead),
    .o_Trail   (trail),
    .o_Done    (done)
  );

  // State register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a byte finishes two cycles after its last SPI edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = XFER;
      XFER:      if (byte_done_q) state_d = more ? WAIT_NEXT : CS_HOLD;
      WAIT_NEXT: if (accept) state_d = XFER;
      CS_HOLD:   if (tmr_q == TW'(CLKS_PER_HALF_BIT - 1)) state_d = CS_GAP;
      CS_GAP:    if (tmr_q == TW'(CS_INACTIVE_CLKS - 1)) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode; ready and CS_n are registered from the next state.
  always_comb begin
    clk_en  = (state_q == XFER);
    ready_d = (state_d == IDLE) || (state_d == WAIT_NEXT);
    cs_n_d  = (state_d == IDLE) || (state_d == CS_GAP);
  end

  // Control registers: handshake, CS, timer, byte counter, received byte.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      cs_n_q      <= 1'b1;
      ready_q     <= 1'b0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= '0;
      rx_cnt_q    <= '0;
      mosi_q      <= 1'b0;
      total_q     <= CW'(1);
      tmr_q       <= '0;
      byte_done_q <= 1'b0;
    end else begin
      cs_n_q      <= cs_n_d;
      ready_q     <= ready_d;
      byte_done_q <= done;
      rx_dv_q     <= byte_done_q;
      tmr_q       <= (state_d != state_q) ? '0 : tmr_q + TW'(1);
      if (byte_done_q) begin
        rx_byte_q <= rx_shift_q;
        rx_cnt_q  <= rx_cnt_q + CW'(1);
      end else if (state_q == CS_HOLD && state_d == CS_GAP) begin
        rx_cnt_q  <= '0;
      end
      if (accept && state_q == IDLE) total_q <= sat_count(i_TX_Count);
      if (accept && !CPHA)    mosi_q <= i_TX_Byte[7];
      else if (shift_en)      mosi_q <= tx_shift_q[7];
    end
  end

  // Shift registers; reloaded on every accepted byte so no reset is needed.
  always_ff @(posedge i_Clk) begin
    if (accept)        tx_shift_q <= CPHA ? i_TX_Byte : {i_TX_Byte[6:0], 1'b0};
    else if (shift_en) tx_shift_q <= {tx_shift_q[6:0], 1'b0};
    if (sample_en)     rx_shift_q <= {rx_shift_q[6:0], i_SPI_MISO};
  end

endmodule
